// File: rtl/spi_rx_deser.sv
// spi_rx_deser - oversampling SPI receive deserializer with a one-entry valid/ready output register.
// Define SPI_RX_SYNC2_EN for a two-flop input synchronizer (default: single register stage).
module spi_rx_deser #(
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs_l,
  input  logic                  spi_sclk,
  input  logic                  spi_data,
  input  logic                  rx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output logic [4:0]            bit_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

  localparam logic [4:0] FULL = 5'(FRAME_BITS);
  localparam logic [4:0] LONG = 5'(FRAME_BITS + 1);

  logic cs_in, sclk_in, data_in;

`ifdef SPI_RX_SYNC2_EN
  localparam int SYNC_STAGES = 2;
  logic cs_m, sclk_m, data_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_m   <= 1'b1;
      sclk_m <= 1'b0;
      data_m <= 1'b0;
    end else begin
      cs_m   <= spi_cs_l;
      sclk_m <= spi_sclk;
      data_m <= spi_data;
    end
  end

  assign cs_in   = cs_m;
  assign sclk_in = sclk_m;
  assign data_in = data_m;
`else
  localparam int SYNC_STAGES = 1;
  assign cs_in   = spi_cs_l;
  assign sclk_in = spi_sclk;
  assign data_in = spi_data;
`endif

  logic       cs_s, sclk_s, data_s, cs_d, sclk_d;
  logic [1:0] flush;
  logic       armed;

  // armed waits for a real high on cs_l so a frame already in progress at reset release is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s   <= 1'b1;
      sclk_s <= 1'b0;
      data_s <= 1'b0;
      cs_d   <= 1'b1;
      sclk_d <= 1'b0;
      flush  <= 2'b00;
      armed  <= 1'b0;
    end else begin
      cs_s   <= cs_in;
      sclk_s <= sclk_in;
      data_s <= data_in;
      cs_d   <= cs_s;
      sclk_d <= sclk_s;
      flush  <= {flush[0], 1'b1};
      armed  <= armed | (flush[SYNC_STAGES-1] & cs_s);
    end
  end

  logic cs_fall, cs_rise, sclk_rise;
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  state_t                state, state_n;
  logic [4:0]            cnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic                  close_good, close_bad, load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // the shift for this cycle is applied before the close decision looks at the count
  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    shreg_n    = shreg;
    close_good = 1'b0;
    close_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 5'd0;
        if (cs_fall) state_n = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          shreg_n = {shreg[FRAME_BITS-2:0], data_s};
          cnt_n   = bit_cnt + 5'd1;
        end
        if (cs_rise) begin
          close_good = (cnt_n == FULL);
          close_bad  = (cnt_n != FULL);
          cnt_n      = 5'd0;
          state_n    = IDLE;
        end else if (cnt_n == FULL) begin
          state_n = WAIT_END;
        end
      end
      WAIT_END: begin
        if (sclk_rise) cnt_n = LONG;
        if (cs_rise) begin
          close_good = (cnt_n == FULL);
          close_bad  = (cnt_n != FULL);
          cnt_n      = 5'd0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load = close_good & (~rx_valid | rx_ready);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 5'd0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bit_cnt   <= cnt_n;
      shreg     <= shreg_n;
      frame_err <= close_bad;
      overrun   <= close_good & rx_valid & ~rx_ready;
      if (load) begin
        rx_data  <= shreg_n;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb/tb_spi_rx_deser.sv - self-checking bench for spi_rx_deser against a frame-level reference model.
module tb_spi_rx_deser;

  logic        clk = 1'b0;
  logic        reset, spi_cs_l, spi_sclk, spi_data, rx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err, overrun, busy;
  logic [4:0]  bit_cnt;

  spi_rx_deser dut (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk),
    .spi_data(spi_data), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

`ifdef SPI_RX_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int obs_ferr = 0;
  int obs_ovr = 0;
  bit rand_ready = 1'b0;

  // frame-level model: one close event per frame, resolved LAT edges after cs_l is driven high
  logic        exp_valid = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
  logic [15:0] exp_data = 16'h0;
  logic        ev_pending = 1'b0;
  int          ev_at = 0, ev_n = 0;
  logic [15:0] ev_w = 16'h0;
  logic        consume;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (reset) begin
      exp_valid  = 1'b0;
      exp_data   = 16'h0;
      ev_pending = 1'b0;
    end else begin
      consume = exp_valid && rx_ready;
      if (ev_pending && cyc == ev_at) begin
        ev_pending = 1'b0;
        if (ev_n != 16) begin
          exp_ferr = 1'b1;
        end else if (!exp_valid || rx_ready) begin
          exp_data  = ev_w;
          exp_valid = 1'b1;
          consume   = 1'b0;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      if (consume) exp_valid = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("rx_valid", rx_valid, exp_valid);
      check("rx_data", rx_data, exp_data);
      check("frame_err", frame_err, exp_ferr);
      check("overrun", overrun, exp_ovr);
      if (frame_err === 1'b1) obs_ferr++;
      if (overrun === 1'b1) obs_ovr++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    exp_valid  = 1'b0;
    exp_data   = 16'h0;
    exp_ferr   = 1'b0;
    exp_ovr    = 1'b0;
    ev_pending = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int n, input int rst_at, input bit ho);
    bit aborted = 1'b0;
    spi_cs_l = 1'b0;
    tick(2);
    for (int i = 0; i < n; i++) begin
      int h = int'($urandom_range(1, 3));
      spi_data = (i < 16) ? w[15-i] : 1'($urandom_range(0, 1));
      spi_sclk = 1'b0;
      tick(h);
      if (i == rst_at) begin
        do_reset();
        aborted = 1'b1;
      end
      spi_sclk = 1'b1;
      tick(h);
    end
    spi_sclk = 1'b0;
    tick(3);
    if (!aborted) begin
      check("bit_cnt_end", bit_cnt, n);
      check("busy_mid", busy, 1);
    end
    spi_cs_l = 1'b1;
    if (!aborted) begin
      ev_w       = w;
      ev_n       = n;
      ev_at      = cyc + LAT;
      ev_pending = 1'b1;
    end
    if (ho) begin
      tick(LAT - 1);
      rx_ready = 1'b1;
      tick(4);
    end else begin
      tick(LAT + 3);
    end
  endtask

  initial begin
    int f0, o0;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int f0, o0;
    reset = 1'b1; spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0; rx_ready = 1'b0;
    tick(3);
    check("rst_rx_data", rx_data, 16'h0000);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick(5);

    rx_ready = 1'b1;
    f0 = obs_ferr;
    send(16'hA569, 16, -1, 1'b0);
    check("t1_data", rx_data, 16'hA569);
    check("t1_no_ferr", obs_ferr - f0, 0);

    rx_ready = 1'b0;
    o0 = obs_ovr;
    send(16'h2563, 16, -1, 1'b0);
    send(16'h9B63, 16, -1, 1'b0);
    check("t2_overrun_once", obs_ovr - o0, 1);
    check("t2_data_held", rx_data, 16'h2563);
    check("t2_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick(3);

    f0 = obs_ferr;
    send(16'hFFFF, 9, -1, 1'b0);
    check("t3_short_ferr", obs_ferr - f0, 1);
    check("t3_no_valid", rx_valid, 0);
    send(16'h6A61, 16, -1, 1'b0);
    check("t3_next_data", rx_data, 16'h6A61);

    f0 = obs_ferr;
    send(16'h1111, 17, -1, 1'b0);
    check("t4_long_ferr", obs_ferr - f0, 1);
    check("t4_no_load", rx_data, 16'h6A61);

    f0 = obs_ferr;
    send(16'hA265, 16, 8, 1'b0);
    check("t5_reset_no_valid", rx_valid, 0);
    send(16'h7564, 16, -1, 1'b0);
    check("t5_no_ferr", obs_ferr - f0, 0);
    check("t5_data", rx_data, 16'h7564);

    rx_ready = 1'b0;
    o0 = obs_ovr;
    send(16'h1234, 16, -1, 1'b0);
    check("t6_first_held", rx_data, 16'h1234);
    send(16'hBEEF, 16, -1, 1'b1);
    check("t6_handoff_no_ovr", obs_ovr - o0, 0);
    check("t6_handoff_data", rx_data, 16'hBEEF);

    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] w;
      int n;
      w = 16'($urandom);
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 17)) : 16;
      send(w, n, -1, 1'b0);
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_rx_deser.md
# spi_rx_deser

SPI receive deserializer sitting directly downstream of the `spi_state` transmitter. It watches `spi_cs_l`, `spi_sclk` and `spi_data`, rebuilds each 16-bit MSB-first frame, and presents the word on a one-entry valid/ready output register. It also flags short or long frames and overruns. It runs on the same `clk` as the transmitter and oversamples the SPI lines; it never uses `spi_sclk` as a clock.

## Interface
- `FRAME_BITS`, 16: bits per frame; `rx_data` width.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `spi_cs_l` in 1: chip select, active low.
- `spi_sclk` in 1: serial clock; bits are sampled on its rising edge.
- `spi_data` in 1: serial data, MSB first.
- `rx_ready` in 1: consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data` out 16: last complete frame.
- `rx_valid` out 1: `rx_data` holds an unconsumed word.
- `frame_err` out 1: one-cycle pulse when a frame closes with a bit count other than 16.
- `overrun` out 1: one-cycle pulse when a good frame is dropped because the output register is full.
- `busy` out 1: high when the FSM is not in IDLE.
- `bit_cnt` out 5: rising edges counted in the current frame, 0..16, saturating at 17.

## Operation
- Input conditioning: `spi_cs_l`, `spi_sclk` and `spi_data` pass through a synchronizer (see Configuration). A further register stage on cs and sclk yields `cs_fall`, `cs_rise` and `sclk_rise`.
- Shift register: on `sclk_rise` in SHIFT, `shreg <= {shreg[14:0], data_s}` and `bit_cnt` increments.
- FSM states:
  - IDLE: `bit_cnt` = 0. Go to SHIFT only on `cs_fall`. If cs_l is already low after reset, stay in IDLE until it goes high and falls again.
  - SHIFT: shift on `sclk_rise`. At `bit_cnt` 16, go to WAIT_END. On `cs_rise` with count below 16, pulse `frame_err`, discard the frame, go to IDLE.
  - WAIT_END: a further `sclk_rise` sets `bit_cnt` to 17 (frame marked long). On `cs_rise`:
    - count 17: pulse `frame_err`, discard.
    - count 16, and output register empty or being consumed this cycle: load `rx_data <= shreg`, set `rx_valid`.
    - count 16, output register full and `rx_ready` low: pulse `overrun`, drop the new word, keep the old one.
    - In every case, go to IDLE.
- Output handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`.
  - `rx_data` is stable while `rx_valid` is high.
  - Load and consume in the same cycle is a hand-off: new word loaded, `rx_valid` stays high, no overrun.
- `cs_rise` and `sclk_rise` in the same cycle: the shift is applied first, then the close decision uses the updated count.
- Reset mid-frame: all state clears immediately and the partial frame is lost. No `frame_err` is issued for it.

## Timing
- Reset values:
  - `rx_data` = 16'h0000, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0, `bit_cnt` = 0.
  - FSM in IDLE; synchronizer flops reset to 1 for cs_l and 0 for sclk/data.
- Latency from the clk edge that first samples `spi_cs_l` high to `rx_valid` high: 2 cycles with the macro defined, 1 cycle without. `frame_err` and `overrun` follow the same latency.
- Each `spi_sclk` level must last at least 1 clk cycle. Data must be stable across the sampled rising edge. The transmitter guarantees both.
- Back-to-back frames need cs_l high for at least 1 clk cycle between frames.

## Configuration
- `SPI_RX_SYNC2_EN` defined: two-flop synchronizer on all three SPI inputs, for use when the transmitter is in an unrelated clock domain.
- Not defined: single register stage; latencies drop by one cycle as stated above. Functional behaviour is otherwise identical.

## Test plan
- Reset with cs_l high, then one frame of 16'hA569 with `rx_ready` = 1 → one `rx_valid` pulse with `rx_data` = 16'hA569, `frame_err` = 0.
- Frames 16'h2563 then 16'h9B63, `rx_ready` held low → first word held, `overrun` pulses once at the second close, `rx_data` stays 16'h2563.
- Frame truncated after 9 bits by cs_l rising → `frame_err` pulse, `rx_valid` stays 0. The next frame, 16'h6A61, is received correctly.
- Frame of 17 sclk edges → `bit_cnt` reaches 17, `frame_err` pulse, no load.
- Assert `reset` after 8 bits of 16'hA265, release it while cs_l is still low → no output for that frame. The following full frame, 16'h7564, is received.
- `rx_ready` rising in the same cycle a new word loads → hand-off with no `overrun`, and `rx_data` changes to the new word.
